// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM encodings
// and the counter width helper.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_PRESS_CHK = 2'd1,
        DB_HELD      = 2'd2,
        DB_REL_CHK   = 2'd3
    } db_state_e;

    // Counter only has to reach STABLE_TICKS-1, so clog2 of the tick count suffices.
    function automatic int db_cnt_width(input int stable_ticks);
        return $clog2(stable_ticks);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, confirmation FSM with counter,
// and registered level / press / release outputs.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int                CNT_W    = db_cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Pulses default low every clk so they last exactly one cycle even when
    // en_tick is held high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DB_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (en_tick) begin
                case (state_q)
                    DB_IDLE: begin
                        if (sync2_q) begin
                            state_q <= DB_PRESS_CHK;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    DB_PRESS_CHK: begin
                        if (!sync2_q) begin
                            state_q <= DB_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= DB_HELD;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    DB_HELD: begin
                        if (!sync2_q) begin
                            state_q <= DB_REL_CHK;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    DB_REL_CHK: begin
                        if (sync2_q) begin
                            state_q <= DB_HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q   <= DB_IDLE;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN raw push-buttons on the en_tick strobe; each button is an
// independent debounce_channel.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BTN      = 5,
    parameter int STABLE_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_tick,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            debounce_channel #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .en_tick     (en_tick),
                .btn_raw     (btn_raw[gi]),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi])
            );
        end
    endgenerate

endmodule
